reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised general-purpose register file with an integrated write scoreboard, the next generation of the core's register heap. It provides two combinational read ports, one synchronous write port, an optional write-to-read bypass, and a per-register busy bit. The decode stage sets a busy bit when it issues an instruction with a destination; writeback clears it. Decode uses the busy flags and the outstanding count to generate RAW/WAW interlocks and drain-before-exception decisions.

## Interface
- DW, 32: data width in bits.
- AW, 5: address width; depth is 2^AW registers.
- ZERO_REG, 1: 1 = register 0 reads as zero, ignores writes and is never busy.
- BYPASS, 1: 1 = a same-cycle write is forwarded to the read ports and busy flags.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ra1, ra2  in  AW  read addresses.
- rd1, rd2  out  DW  read data, combinational.
- busy1, busy2  out  1  a pending write targets ra1 / ra2.
- we  in  1  writeback enable.
- wa  in  AW  writeback address.
- wd  in  DW  writeback data.
- iss_valid  in  1  reserve a destination register.
- iss_wa  in  AW  destination being reserved.
- iss_waw  out  1  iss_wa is already busy (WAW hazard), combinational.
- flush  in  1  clear all busy bits, such as on a pipeline flush.
- busy_cnt  out  AW+1  number of busy registers, registered.

## Operation
- Storage: 2^AW × DW data array, 2^AW busy bits, and a busy_cnt register.
- Reset (rst_n low, asynchronous): all data registers = 0, all busy bits = 0, busy_cnt = 0. Combinational outputs follow from that state.
- Write: on a rising edge with we = 1, mem[wa] <= wd and busy[wa] is cleared. With ZERO_REG = 1 and wa = 0, the write is dropped.
- Read, with x ∈ {1, 2}:
  - rdx = 0 when ZERO_REG and rax = 0.
  - Otherwise rdx = wd when BYPASS and we and wa == rax.
  - Otherwise rdx = mem[rax].
- Busy flag: busyx = busy[rax] & ~(BYPASS & we & wa == rax). It is forced to 0 for register 0 when ZERO_REG.
- iss_waw uses the same expression as busyx, applied to iss_wa. It is independent of iss_valid.
- Issue: on an edge with iss_valid = 1 and (iss_wa != 0 or ZERO_REG = 0), busy[iss_wa] is set.
- Priority for each busy bit, highest first:
  - flush: all bits become 0 and issue is ignored.
  - Issue set.
  - Writeback clear.
- Same register issued and written back in one cycle: the bit ends at 1, because the new producer wins.
- Issue to a register that is already busy: the bit stays 1. Decode is responsible for stalling on iss_waw. A single writeback later clears the bit.
- flush does not block a same-cycle data write; mem is still updated.
- busy_cnt always equals the population count of the busy bits after the edge. It is maintained incrementally (+1 set, −1 clear, ±0 when both or no-op) or recomputed; either way it must match the popcount exactly. Maximum value is 2^AW (2^AW − 1 with ZERO_REG), so there is no overflow.

## Timing
- Read latency is 0 cycles: combinational from ra, we, wa and wd.
- A write on edge N is visible through mem from cycle N+1, and in cycle N via the bypass when BYPASS = 1.
- When BYPASS = 0, busyx remains 1 during the writeback cycle and drops in cycle N+1.
- Issue on edge N: busyx and iss_waw for that register are 1 from cycle N+1.
- flush on edge N: all busy flags and busy_cnt are 0 from cycle N+1.
- Reset asserted mid-operation clears state immediately. The first edge after rst_n rises behaves like a normal cycle.

## Test plan
- Reset then read all addresses: every rdx = 0, busy_cnt = 0. Write 0xDEADBEEF to r0, then read r0 → 0 (ZERO_REG = 1).
- Write 0x12345678 to r5, setting ra1 = 5 in the same cycle: rd1 = 0x12345678 combinationally (BYPASS = 1). With BYPASS = 0, rd1 shows the old value and then the new value one cycle later.
- Issue r7 → busy1 = 1 next cycle and busy_cnt = 1. Write back r7 → busy1 = 0 in that cycle (bypass) and busy_cnt = 0 next cycle.
- Issue r9 and write back r9 in the same cycle → busy[9] stays 1 and busy_cnt is unchanged (+1 −1 on the same bit gives 1). iss_waw = 1 for iss_wa = 9.
- Issue r1..r31 on consecutive cycles → busy_cnt = 31. Issue r0 → no change. Assert flush together with issue r3 → busy_cnt = 0 and all busy flags are 0.
- With r4 busy and a write of 0xA5A5A5A5 pending, pull rst_n low mid-cycle → rd of r4 = 0 and busy = 0 immediately, before any clock edge.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass and a per-register busy scoreboard for decode interlocks.
module reg_file_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic          busy1,
    output logic          busy2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_wa,
    output logic          iss_waw,
    input  logic          flush,
    output logic [AW:0]   busy_cnt
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;

    logic write_ok;
    logic iss_ok;
    logic hit1, hit2, hit_iss;
    logic zero1, zero2, zero_iss;

    assign write_ok = we && !((ZERO_REG != 0) && (wa == '0));
    assign iss_ok   = iss_valid && !((ZERO_REG != 0) && (iss_wa == '0));

    assign hit1    = (BYPASS != 0) && we && (wa == ra1);
    assign hit2    = (BYPASS != 0) && we && (wa == ra2);
    assign hit_iss = (BYPASS != 0) && we && (wa == iss_wa);

    assign zero1    = (ZERO_REG != 0) && (ra1 == '0);
    assign zero2    = (ZERO_REG != 0) && (ra2 == '0);
    assign zero_iss = (ZERO_REG != 0) && (iss_wa == '0);

    assign rd1 = zero1 ? '0 : (hit1 ? wd : mem[ra1]);
    assign rd2 = zero2 ? '0 : (hit2 ? wd : mem[ra2]);

    assign busy1   = !zero1    && busy[ra1]    && !hit1;
    assign busy2   = !zero2    && busy[ra2]    && !hit2;
    assign iss_waw = !zero_iss && busy[iss_wa] && !hit_iss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_ok) begin
            mem[wa] <= wd;
        end
    end

    // Issue is applied after writeback so a new producer wins on the same register.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (write_ok) begin
                busy_nxt[wa] = 1'b0;
            end
            if (iss_ok) begin
                busy_nxt[iss_wa] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an array-based model.
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] ra1, ra2, wa, iss_wa;
    logic [DW-1:0] rd1, rd2, wd;
    logic          busy1, busy2, we, iss_valid, iss_waw, flush;
    logic [AW:0]   busy_cnt;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_mem  [N];
    bit            m_busy [N];

    reg_file_sb #(.DW(DW), .AW(AW), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2),
        .we(we), .wa(wa), .wd(wd),
        .iss_valid(iss_valid), .iss_wa(iss_wa), .iss_waw(iss_waw),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        return m_busy[a] && !(we && wa == a);
    endfunction

    function automatic int exp_cnt();
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(m_busy[i]);
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        if (we && wa != 0) m_mem[wa] = wd;
        if (flush) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        end else begin
            if (we) m_busy[wa] = 1'b0;
            if (iss_valid && iss_wa != 0) m_busy[iss_wa] = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("rd1",      rd1,              exp_rd(ra1));
        chk("rd2",      rd2,              exp_rd(ra2));
        chk("busy1",    32'(busy1),       32'(exp_busy(ra1)));
        chk("busy2",    32'(busy2),       32'(exp_busy(ra2)));
        chk("iss_waw",  32'(iss_waw),     32'(exp_busy(iss_wa)));
        chk("busy_cnt", 32'(busy_cnt),    32'(exp_cnt()));
    endtask

    // Inputs are applied just after a rising edge; outputs compared on the falling edge.
    task automatic cyc();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we = 0; iss_valid = 0; flush = 0;
    endtask

    initial begin
        rst_n = 0; ra1 = 0; ra2 = 0; wa = 0; wd = 0; iss_wa = 0;
        idle();
        model_clear();
        repeat (3) cyc();
        rst_n = 1;

        for (int a = 0; a < N; a++) begin
            ra1 = AW'(a); ra2 = AW'(N - 1 - a);
            #2;
            chk("reset_rd1", rd1, 32'h0);
            chk("reset_rd2", rd2, 32'h0);
            cyc();
        end
        chk("reset_cnt", 32'(busy_cnt), 32'd0);

        we = 1; wa = 0; wd = 32'hDEADBEEF; ra1 = 0;
        #2 chk("r0_bypass", rd1, 32'h0);
        cyc();
        idle();
        #2 chk("r0_read", rd1, 32'h0);
        cyc();

        we = 1; wa = 5; wd = 32'h12345678; ra1 = 5;
        #2 chk("r5_bypass", rd1, 32'h12345678);
        cyc();
        idle();
        #2 chk("r5_mem", rd1, 32'h12345678);
        cyc();

        iss_valid = 1; iss_wa = 7;
        cyc();
        idle(); ra1 = 7;
        #2 chk("r7_busy", 32'(busy1), 32'd1);
        chk("r7_cnt", 32'(busy_cnt), 32'd1);
        we = 1; wa = 7; wd = 32'h00000777;
        #1 chk("r7_wb_bypass_busy", 32'(busy1), 32'd0);
        cyc();
        idle();
        #2 chk("r7_cnt_clear", 32'(busy_cnt), 32'd0);
        cyc();

        iss_valid = 1; iss_wa = 9;
        cyc();
        we = 1; wa = 9; wd = 32'h99; iss_valid = 1; iss_wa = 9;
        cyc();
        idle(); ra1 = 9; iss_wa = 9;
        #2 chk("r9_busy", 32'(busy1), 32'd1);
        chk("r9_waw", 32'(iss_waw), 32'd1);
        chk("r9_cnt", 32'(busy_cnt), 32'd1);
        we = 1; wa = 9;
        cyc();
        idle();

        for (int i = 1; i < N; i++) begin
            iss_valid = 1; iss_wa = AW'(i);
            cyc();
        end
        idle();
        #2 chk("cnt_31", 32'(busy_cnt), 32'd31);
        iss_valid = 1; iss_wa = 0;
        cyc();
        idle(); ra1 = 0;
        #2 chk("cnt_r0", 32'(busy_cnt), 32'd31);
        chk("r0_busy", 32'(busy1), 32'd0);
        flush = 1; iss_valid = 1; iss_wa = 3;
        cyc();
        idle(); ra1 = 3;
        #2 chk("flush_cnt", 32'(busy_cnt), 32'd0);
        chk("flush_busy3", 32'(busy1), 32'd0);
        cyc();

        we = 1; wa = 4; wd = 32'h11;
        cyc();
        idle(); iss_valid = 1; iss_wa = 4;
        cyc();
        idle(); ra1 = 4; wa = 4; wd = 32'hA5A5A5A5;
        #2 chk("r4_busy_pre", 32'(busy1), 32'd1);
        chk("r4_rd_pre", rd1, 32'h11);
        rst_n = 0;
        #1 chk("rst_rd", rd1, 32'h0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_cnt", 32'(busy_cnt), 32'd0);
        model_clear();
        cyc();
        rst_n = 1;

        for (int c = 0; c < 3000; c++) begin
            we        = ($urandom_range(0, 2) != 0);
            wa        = AW'($urandom);
            wd        = $urandom;
            iss_valid = ($urandom_range(0, 2) != 0);
            iss_wa    = AW'($urandom);
            flush     = ($urandom_range(0, 40) == 0);
            ra1       = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
            ra2       = ($urandom_range(0, 3) == 0) ? iss_wa : AW'($urandom);
            cyc();
        end
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
